// File: rtl/pc_gen.sv
// Fetch-address generator: fetch PC, group stepping, flush/branch redirects with a one-entry pending buffer.
// Optional feature macro: PC_ADEL_CHECK_EN (misaligned-fetch flag; redirect targets loaded unmodified).
module pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int unsigned FETCH_W      = 1,
    parameter int unsigned STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [31:0]        new_pc,
    input  logic               branch_flag_i,
    input  logic [31:0]        branch_target_address_i,
    input  logic               fetch_ready_i,
    output logic [31:0]        pc,
    output logic               ce,
    output logic [FETCH_W-1:0] inst_mask_o,
    output logic               adel_o
);

    localparam int unsigned G  = 4 * FETCH_W;
    localparam int unsigned GB = $clog2(G);
    localparam logic [31:0] G_MASK = 32'(G - 1);
    localparam logic [31:0] G_STEP = 32'(G);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_v_q, pend_v_d;
    logic        ce_q;
    logic        advance;
    logic        unused_bits;

    function automatic logic [31:0] fix_target(input logic [31:0] t);
`ifdef PC_ADEL_CHECK_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    assign advance = ce_q & fetch_ready_i & ~stall[0];

    always_comb begin
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        pend_v_d  = pend_v_q;
        if (!ce_q) begin
            // Until fetch is enabled the PC is pinned and redirects are ignored.
            pc_d     = RESET_VECTOR;
            pend_v_d = 1'b0;
        end else if (flush) begin
            pc_d     = fix_target(new_pc);
            pend_v_d = 1'b0;
        end else if (advance && branch_flag_i) begin
            pc_d     = fix_target(branch_target_address_i);
            pend_v_d = 1'b0;
        end else if (advance && pend_v_q) begin
            pc_d     = fix_target(pend_pc_q);
            pend_v_d = 1'b0;
        end else if (advance) begin
            pc_d = (pc_q & ~G_MASK) + G_STEP;
        end else if (branch_flag_i) begin
            pend_pc_d = branch_target_address_i;
            pend_v_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_VECTOR;
            ce_q      <= 1'b0;
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ce_q      <= 1'b1;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign pc = pc_q;
    assign ce = ce_q;

    generate
        if (FETCH_W == 1) begin : g_single
            assign inst_mask_o = 1'b1;
        end else begin : g_multi
            always_comb begin
                inst_mask_o = '0;
                for (int unsigned i = 0; i < FETCH_W; i++) begin
                    inst_mask_o[i] = (i >= 32'(pc_q[GB-1:2]));
                end
            end
        end
    endgenerate

`ifdef PC_ADEL_CHECK_EN
    assign adel_o = ce_q & (pc_q[1:0] != 2'b00);
`else
    assign adel_o = 1'b0;
`endif

    assign unused_bits = ^{stall[STALL_W-1:1], new_pc[1:0], branch_target_address_i[1:0]};

endmodule
